// File: rtl/seven_seg_scanner_n.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner_n
//   N-digit anode scanner for multiplexed common-anode 7-segment displays.
//   A single internal dwell counter times each digit, so no divided clock is
//   needed. Digits whose mask bit is clear are skipped. An optional blank gap
//   with every anode off separates consecutive digits to suppress ghosting.
//
// Ports
//   clk          in   1       system clock, rising edge
//   reset        in   1       synchronous, active-high
//   enable       in   1       1 = scan runs; 0 = timing frozen, all anodes off
//   digit_mask   in   DIGITS  bit i set: digit i takes part in the scan
//   anode        out  DIGITS  active-low anode drives (registered)
//   digit_sel    out  SEL_W   index of the lit/next digit (registered)
//   blanking     out  1       1 during the blank gap or while disabled
//   frame_start  out  1       1-clk pulse when the scan wraps to a lower/equal index
// ---------------------------------------------------------------------------
module seven_seg_scanner_n #(
  parameter  int unsigned DIGITS       = 4,
  parameter  int unsigned DWELL_CYCLES = 100000,
  parameter  int unsigned BLANK_CYCLES = 1000,
  localparam int unsigned SEL_W        = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIGITS-1:0] digit_mask,
  output logic [DIGITS-1:0] anode,
  output logic [SEL_W-1:0]  digit_sel,
  output logic              blanking,
  output logic              frame_start
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t            st, st_n;
  logic [SEL_W-1:0]  sel, sel_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [SEL_W-1:0]  nxt_sel;
  logic [SEL_W-1:0]  cand;
  logic              found;
  logic              wrap, wrap_r;
  logic [DIGITS-1:0] anode_n;

  // Next enabled digit after sel, searching forward with wrap-around.
  // Falls back to sel itself when the mask is empty.
  always_comb begin
    nxt_sel = sel;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= DIGITS; k++) begin
      cand = SEL_W'((32'(sel) + k) % DIGITS);
      if (!found && digit_mask[cand]) begin
        nxt_sel = cand;
        found   = 1'b1;
      end
    end
  end

  // Scan state register
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= ST_SHOW;
      sel <= '0;
      cnt <= '0;
    end else begin
      st  <= st_n;
      sel <= sel_n;
      cnt <= cnt_n;
    end
  end

  // Next-state logic; everything holds while enable is low so the remaining
  // dwell is preserved across a pause.
  always_comb begin
    st_n  = st;
    sel_n = sel;
    cnt_n = cnt;
    wrap  = 1'b0;
    if (enable) begin
      unique case (st)
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            cnt_n = '0;
            sel_n = nxt_sel;
            wrap  = (nxt_sel <= sel);
            st_n  = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_n = '0;
            st_n  = ST_SHOW;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          st_n = ST_SHOW;
        end
      endcase
    end
  end

  // At most one anode can be low: only the index equal to sel qualifies.
  always_comb begin
    anode_n = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      anode_n[i] = ~(enable && (st == ST_SHOW) && (sel == SEL_W'(i)) && digit_mask[i]);
    end
  end

  // Output register stage. The wrap flag is delayed one extra clk so the
  // frame_start pulse lines up with the registered digit_sel showing the
  // wrapped index.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode       <= '1;
      digit_sel   <= '0;
      blanking    <= 1'b0;
      frame_start <= 1'b0;
      wrap_r      <= 1'b0;
    end else begin
      anode       <= anode_n;
      digit_sel   <= sel;
      blanking    <= (st == ST_BLANK) || !enable;
      wrap_r      <= wrap;
      frame_start <= wrap_r;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner_n.sv
module tb_seven_seg_scanner_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] digit_mask;

  logic [3:0] anode,  nb_anode;
  logic [1:0] digit_sel, nb_digit_sel;
  logic       blanking, nb_blanking;
  logic       frame_start, nb_frame_start;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seven_seg_scanner_n #(.DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .digit_mask(digit_mask),
    .anode(anode), .digit_sel(digit_sel), .blanking(blanking), .frame_start(frame_start)
  );

  seven_seg_scanner_n #(.DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) u_nb (
    .clk(clk), .reset(reset), .enable(enable), .digit_mask(digit_mask),
    .anode(nb_anode), .digit_sel(nb_digit_sel), .blanking(nb_blanking),
    .frame_start(nb_frame_start)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two clks, then release; the next clk edge is cycle 0.
  task automatic start(input logic [3:0] m);
    reset = 1'b1;
    enable = 1'b1;
    digit_mask = m;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    digit_mask = 4'b1111;
    tick();
    tick();
    vectors++;
    if (anode !== 4'b1111) begin miscompares++; $display("FAIL reset_anode got %b want %b", anode, 4'b1111); end
    vectors++;
    if (digit_sel !== 2'd0) begin miscompares++; $display("FAIL reset_sel got %0d want 0", digit_sel); end
    vectors++;
    if (blanking !== 1'b0) begin miscompares++; $display("FAIL reset_blanking got %b want 0", blanking); end
    vectors++;
    if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    vectors++;
    if (nb_anode !== 4'b1111) begin miscompares++; $display("FAIL reset_nb_anode got %b want 1111", nb_anode); end
  endtask

  // mask 1111: 6-clk digit period (4 lit + 2 blank), 24-clk frame
  task automatic test_full_scan();
    logic [3:0] one, exp_an;
    logic [1:0] exp_sel;
    start(4'b1111);
    for (int c = 0; c < 54; c++) begin
      int p, d, w;
      tick();
      p = c % 24; d = p / 6; w = p % 6;
      one = 4'b0001 << d;
      exp_an  = (w < 4) ? ~one : 4'b1111;
      exp_sel = (w < 4) ? 2'(d) : 2'((d + 1) % 4);
      vectors++;
      if (anode !== exp_an) begin miscompares++; $display("FAIL full_anode c=%0d got %b want %b", c, anode, exp_an); end
      vectors++;
      if (digit_sel !== exp_sel) begin miscompares++; $display("FAIL full_sel c=%0d got %0d want %0d", c, digit_sel, exp_sel); end
      vectors++;
      if (blanking !== (w >= 4)) begin miscompares++; $display("FAIL full_blanking c=%0d got %b want %b", c, blanking, (w >= 4)); end
      vectors++;
      if (frame_start !== (p == 22)) begin miscompares++; $display("FAIL full_frame_start c=%0d got %b want %b", c, frame_start, (p == 22)); end
    end
  endtask

  // mask 0101: digits 0 and 2 only, 12-clk frame
  task automatic test_mask_0101();
    logic [3:0] one, exp_an;
    logic [1:0] exp_sel;
    start(4'b0101);
    for (int c = 0; c < 30; c++) begin
      int p, d, w;
      tick();
      p = c % 12; d = (p < 6) ? 0 : 2; w = p % 6;
      one = 4'b0001 << d;
      exp_an  = (w < 4) ? ~one : 4'b1111;
      exp_sel = (w < 4) ? 2'(d) : 2'((d == 0) ? 2 : 0);
      vectors++;
      if (anode !== exp_an) begin miscompares++; $display("FAIL m0101_anode c=%0d got %b want %b", c, anode, exp_an); end
      vectors++;
      if (digit_sel !== exp_sel) begin miscompares++; $display("FAIL m0101_sel c=%0d got %0d want %0d", c, digit_sel, exp_sel); end
      vectors++;
      if (frame_start !== (p == 10)) begin miscompares++; $display("FAIL m0101_frame_start c=%0d got %b want %b", c, frame_start, (p == 10)); end
    end
  endtask

  // mask 0000: dark, sel frozen, timing and wrap pulses still run
  task automatic test_mask_0000();
    start(4'b0000);
    for (int c = 0; c < 18; c++) begin
      int w;
      tick();
      w = c % 6;
      vectors++;
      if (anode !== 4'b1111) begin miscompares++; $display("FAIL m0000_anode c=%0d got %b want 1111", c, anode); end
      vectors++;
      if (digit_sel !== 2'd0) begin miscompares++; $display("FAIL m0000_sel c=%0d got %0d want 0", c, digit_sel); end
      vectors++;
      if (blanking !== (w >= 4)) begin miscompares++; $display("FAIL m0000_blanking c=%0d got %b want %b", c, blanking, (w >= 4)); end
      vectors++;
      if (frame_start !== (w == 4)) begin miscompares++; $display("FAIL m0000_frame_start c=%0d got %b want %b", c, frame_start, (w == 4)); end
    end
  endtask

  // Pause after 2 clks of digit 1; the remaining 2 clks of dwell survive.
  task automatic test_enable_pause();
    start(4'b1111);
    for (int c = 0; c < 8; c++) tick();
    vectors++;
    if (anode !== 4'b1101) begin miscompares++; $display("FAIL pause_pre_anode got %b want 1101", anode); end
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (anode !== 4'b1111) begin miscompares++; $display("FAIL pause_anode k=%0d got %b want 1111", c, anode); end
      vectors++;
      if (blanking !== 1'b1) begin miscompares++; $display("FAIL pause_blanking k=%0d got %b want 1", c, blanking); end
      vectors++;
      if (digit_sel !== 2'd1) begin miscompares++; $display("FAIL pause_sel k=%0d got %0d want 1", c, digit_sel); end
    end
    enable = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (anode !== 4'b1101) begin miscompares++; $display("FAIL resume_anode k=%0d got %b want 1101", c, anode); end
      vectors++;
      if (blanking !== 1'b0) begin miscompares++; $display("FAIL resume_blanking k=%0d got %b want 0", c, blanking); end
    end
    tick();
    vectors++;
    if (anode !== 4'b1111) begin miscompares++; $display("FAIL resume_end_anode got %b want 1111", anode); end
    vectors++;
    if (blanking !== 1'b1) begin miscompares++; $display("FAIL resume_end_blanking got %b want 1", blanking); end
  endtask

  // Reset while the scanner sits in the gap after digit 2.
  task automatic test_reset_in_blank();
    start(4'b1111);
    for (int c = 0; c < 16; c++) tick();
    vectors++;
    if (anode !== 4'b1011) begin miscompares++; $display("FAIL rib_pre_anode got %b want 1011", anode); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (anode !== 4'b1111) begin miscompares++; $display("FAIL rib_anode got %b want 1111", anode); end
    vectors++;
    if (digit_sel !== 2'd0) begin miscompares++; $display("FAIL rib_sel got %0d want 0", digit_sel); end
    vectors++;
    if (blanking !== 1'b0) begin miscompares++; $display("FAIL rib_blanking got %b want 0", blanking); end
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (anode !== 4'b1110) begin miscompares++; $display("FAIL rib_restart_anode k=%0d got %b want 1110", c, anode); end
    end
    tick();
    vectors++;
    if (anode !== 4'b1111) begin miscompares++; $display("FAIL rib_gap_anode got %b want 1111", anode); end
  endtask

  // BLANK_CYCLES = 0: back-to-back digits, 16-clk frame, no gap at all
  task automatic test_no_blank();
    logic [3:0] one, exp_an;
    start(4'b1111);
    for (int c = 0; c < 40; c++) begin
      int d;
      tick();
      d = (c / 4) % 4;
      one = 4'b0001 << d;
      exp_an = ~one;
      vectors++;
      if (nb_anode !== exp_an) begin miscompares++; $display("FAIL nb_anode c=%0d got %b want %b", c, nb_anode, exp_an); end
      vectors++;
      if (nb_digit_sel !== 2'(d)) begin miscompares++; $display("FAIL nb_sel c=%0d got %0d want %0d", c, nb_digit_sel, d); end
      vectors++;
      if (nb_blanking !== 1'b0) begin miscompares++; $display("FAIL nb_blanking c=%0d got %b want 0", c, nb_blanking); end
      vectors++;
      if (nb_frame_start !== (c >= 16 && c % 16 == 0)) begin
        miscompares++;
        $display("FAIL nb_frame_start c=%0d got %b want %b", c, nb_frame_start, (c >= 16 && c % 16 == 0));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    digit_mask = 4'b0000;
    test_reset();
    test_full_scan();
    test_mask_0101();
    test_mask_0000();
    test_enable_pause();
    test_reset_in_blank();
    test_no_blank();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
